// File: rtl/option_stream_unpacker.sv
// rtl/option_stream_unpacker.sv - Option-word decoder feeding a valid/ready FIFO with None/drop statistics
module option_stream_unpacker #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       _i_clk,
    input  logic                       _i_rst_n,
    input  logic [DATA_W:0]            _i_opt,
    input  logic                       _i_flush,
    output logic [DATA_W-1:0]          _o_data,
    output logic                       _o_valid,
    input  logic                       _i_ready,
    output logic [$clog2(DEPTH):0]     _o_count,
    output logic [CNT_W-1:0]           _o_none_cnt,
    output logic [CNT_W-1:0]           _o_drop_cnt,
    output logic                       _o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CNT_W-1:0]  r_none_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              r_overflow;

    logic w_is_none;
    logic w_push_req;
    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_is_none  = _i_opt[DATA_W];
    assign w_push_req = !_i_opt[DATA_W];
    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = w_valid && _i_ready && !_i_flush;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign w_push     = w_push_req && !_i_flush && (!w_full || w_pop);
    assign w_drop     = w_push_req && !_i_flush && w_full && !w_pop;

    always_ff @(posedge _i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= _i_opt[DATA_W-1:0];
        end
    end

    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (_i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            r_none_cnt <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_is_none && (r_none_cnt != {CNT_W{1'b1}})) begin
                r_none_cnt <= r_none_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {CNT_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign _o_valid    = w_valid;
    assign _o_data     = w_valid ? r_mem[r_rd_ptr] : '0;
    assign _o_count    = r_count;
    assign _o_none_cnt = r_none_cnt;
    assign _o_drop_cnt = r_drop_cnt;
    assign _o_overflow = r_overflow;
endmodule

// File: doc/option_stream_unpacker.md
# option_stream_unpacker

Consumer end of the Option-encoded word stream produced by Spade `Option<int<DATA_W>>` outputs: it decodes each `{tag, payload}` word, buffers `Some` payloads in a small FIFO, and re-presents them on a valid/ready stream. It sits between a free-running Spade pipeline, which has no backpressure, and a downstream consumer that can stall. It also counts `None` words and dropped payloads.

## Interface
Parameters:
- `DATA_W`, default 16: payload width.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, at least 2.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `_i_clk`, in, 1: clock. All state updates on the rising edge.
- `_i_rst_n`, in, 1: asynchronous, active-low reset.
- `_i_opt`, in, DATA_W+1: Option word, sampled every cycle.
  - Bit DATA_W is the tag: 0 means `Some`, 1 means `None`.
  - Bits DATA_W-1:0 are the payload. They are don't-care when the tag is 1.
- `_i_flush`, in, 1: synchronous FIFO clear.
- `_o_data`, out, DATA_W: payload at the FIFO head.
- `_o_valid`, out, 1: FIFO non-empty.
- `_i_ready`, in, 1: consumer accepts the head this cycle.
- `_o_count`, out, clog2(DEPTH)+1: current occupancy.
- `_o_none_cnt`, out, CNT_W: number of `None` words seen. Saturating.
- `_o_drop_cnt`, out, CNT_W: number of `Some` payloads lost to overflow. Saturating.
- `_o_overflow`, out, 1: sticky flag, set on the first drop.

## Operation
- **Decode, every cycle when not in reset:**
  - Tag 0 is a push request carrying payload `_i_opt[DATA_W-1:0]`.
  - Tag 1 increments `_o_none_cnt`. It is never pushed.
  - Decode does not depend on `_i_ready`.
- **Pop:** a pop occurs when `_o_valid && _i_ready`. `_i_ready` while empty has no effect.
- **Push:**
  - Accepted if `count < DEPTH`.
  - Also accepted if `count == DEPTH` and a pop happens in the same cycle. The freed slot is reused, so the count stays at DEPTH and nothing is dropped.
  - Otherwise the payload is discarded, `_o_drop_cnt` increments and `_o_overflow` sets.
- **Storage:** circular buffer with read and write pointers of clog2(DEPTH) bits, plus an occupancy counter.
  - Both pointers wrap from DEPTH-1 to 0.
  - Order is strict FIFO.
- **Occupancy update:**
  - Push with no pop: +1.
  - Pop with no push: -1.
  - Both, or neither: unchanged.
- **Counters:** `_o_none_cnt` and `_o_drop_cnt` saturate at 2^CNT_W-1 and never wrap.
- **`_o_overflow`:** cleared only by reset. Flush does not clear it.
- **`_i_flush`:** has priority over push and pop in its cycle.
  - Pointers and count go to 0.
  - Any push or pop requested in that cycle is ignored.
  - An ignored push does not count as a drop.
  - A `None` word in the flush cycle is still counted.
  - Statistics counters are untouched.
- **Reset, asynchronous on `_i_rst_n` low:**
  - Pointers, count, `_o_none_cnt`, `_o_drop_cnt` and `_o_overflow` all go to 0.
  - So `_o_valid` = 0, `_o_count` = 0, and `_o_data` = 0. Storage is cleared, or the output is gated to 0 while empty.
  - Reset mid-operation discards all buffered data.
- **Empty condition:** `_o_data` is 0 whenever `_o_valid` = 0.

## Timing
- **Latency:** a `Some` word sampled at edge N appears at `_o_data`/`_o_valid` after edge N. This is one cycle of latency when the FIFO was empty.
- **Outputs:** `_o_valid`, `_o_data`, `_o_count` and the counters are all registered or derived only from registers. There is no combinational path from `_i_opt` or `_i_ready` to any output.
- **Throughput:** one push and one pop per cycle, sustained.
- **Handshake:** `_o_data` is held stable while `_o_valid && !_i_ready`.
- **Reset release:** deassertion is synchronous to `_i_clk` externally. The first sample is taken at the first rising edge with `_i_rst_n` high.

## Test plan
1. **Reset.** Drive `_i_opt` = 17'h1_0000 with `_i_rst_n` low.
   - Required: all outputs 0.
   - Then release reset and apply 3 cycles of `None`. Required: `_o_none_cnt` = 3, `_o_valid` = 0.
2. **Single pass-through.** `_i_ready` = 1; apply `{0, 16'd123}` for 1 cycle, then `None`.
   - Required: next cycle `_o_valid` = 1, `_o_data` = 123.
   - Following cycle: `_o_valid` = 0, `_o_count` = 0.
3. **Fill and overflow.** `_i_ready` = 0; push payloads 1..6.
   - Required: `_o_count` = 4, `_o_drop_cnt` = 2, `_o_overflow` = 1.
   - Then raise `_i_ready`. Required: output sequence 1, 2, 3, 4, then `_o_valid` = 0.
4. **Full with simultaneous push and pop.** Start full with 10, 11, 12, 13 and `_i_ready` = 1; push 14.
   - Required: no drop, `_o_count` stays 4.
   - Drain order: 10, 11, 12, 13, 14.
5. **Wrap-around.** Stream 20 consecutive `Some` payloads 100..119 with `_i_ready` = 1.
   - Required: identical order out, one-cycle delay, `_o_drop_cnt` = 0, pointers wrap 5 times.
6. **Flush and mid-run reset.** Hold 3 entries; assert `_i_flush` together with a `Some`.
   - Required: next cycle `_o_count` = 0 and `_o_drop_cnt` unchanged.
   - Then refill 2 entries and pulse `_i_rst_n` low between edges. Required: all outputs 0 immediately, without waiting for a clock edge.
